// File: rtl/avmm_m0_arb.sv
// avmm_m0_arb: shares one Avalon-MM peripheral master port between two
// requesters. Round-robin grant held for one whole transfer, with a watchdog
// that forcibly ends transfers the downstream slave never acknowledges.
module avmm_m0_arb #(
  parameter int                 ADDR_W      = 8,
  parameter int                 DATA_W      = 8,
  parameter int                 TIMEOUT_CYC = 256,
  parameter logic [DATA_W-1:0]  ERR_DATA    = 8'hFF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,

  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_waitrequest,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_waitrequest,

  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest,

  output logic [1:0]        grant,
  output logic              timeout_pulse,
  output logic [15:0]       timeout_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TERM = 2'd2
  } state_t;

  // The timer holds the number of stalled BUSY cycles already elapsed. A stall
  // in the cycle where it equals TIMEOUT_CYC-2 is the one that would bring it
  // to TIMEOUT_CYC-1, so that cycle decides between completion and TERM.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 2);

  state_t              state, state_nx;
  logic [1:0]          grant_nx;
  logic                rr_ptr, rr_nx;
  logic [15:0]         timer, timer_nx;
  logic [15:0]         tcnt_nx;

  logic                req0, req1;
  logic                pick1;
  logic                owner;
  logic                g_rd, g_wr, g_req;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;

  // Saturating increment for the timeout event counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req0  = s0_read | s0_write;
  assign req1  = s1_read | s1_write;
  // With both requesting rr_ptr decides; otherwise whoever is asking wins.
  assign pick1 = (req0 & req1) ? rr_ptr : req1;

  // grant is one-hot, so its upper bit alone identifies the owner.
  assign owner   = grant[1];
  assign g_rd    = owner ? s1_read      : s0_read;
  assign g_wr    = owner ? s1_write     : s0_write;
  assign g_addr  = owner ? s1_address   : s0_address;
  assign g_wdata = owner ? s1_writedata : s0_writedata;
  assign g_req   = g_rd | g_wr;

  // State, grant, round-robin pointer, watchdog timer and timeout counter.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state         <= ST_IDLE;
      grant         <= 2'b00;
      rr_ptr        <= 1'b0;
      timer         <= 16'd0;
      timeout_count <= 16'd0;
    end else begin
      state         <= state_nx;
      grant         <= grant_nx;
      rr_ptr        <= rr_nx;
      timer         <= timer_nx;
      timeout_count <= tcnt_nx;
    end
  end

  // Next-state logic and all port outputs; the master side follows the owner
  // combinationally while BUSY and is quiet in IDLE and TERM.
  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    rr_nx          = rr_ptr;
    timer_nx       = timer;
    tcnt_nx        = timeout_count;

    m_read         = 1'b0;
    m_write        = 1'b0;
    m_address      = '0;
    m_writedata    = '0;
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    s0_readdata    = '0;
    s1_readdata    = '0;
    timeout_pulse  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          state_nx = ST_BUSY;
          grant_nx = pick1 ? 2'b10 : 2'b01;
          timer_nx = 16'd0;
        end
      end

      ST_BUSY: begin
        // A write strobe takes precedence over a simultaneous read strobe.
        m_read      = g_rd & ~g_wr;
        m_write     = g_wr;
        m_address   = g_addr;
        m_writedata = g_wdata;
        if (owner) begin
          s1_waitrequest = m_waitrequest;
          s1_readdata    = m_readdata;
        end else begin
          s0_waitrequest = m_waitrequest;
          s0_readdata    = m_readdata;
        end

        // Owner dropping its strobes abandons the transfer; a real
        // acknowledge always beats the watchdog in the same cycle.
        if (!g_req || !m_waitrequest) begin
          state_nx = ST_IDLE;
          grant_nx = 2'b00;
          rr_nx    = ~owner;
          timer_nx = 16'd0;
        end else if (timer == TIMER_LAST) begin
          state_nx = ST_TERM;
        end else begin
          timer_nx = timer + 16'd1;
        end
      end

      ST_TERM: begin
        // Release the stuck requester with an error response for reads.
        timeout_pulse = 1'b1;
        if (owner) begin
          s1_waitrequest = 1'b0;
          s1_readdata    = (g_rd & ~g_wr) ? ERR_DATA : '0;
        end else begin
          s0_waitrequest = 1'b0;
          s0_readdata    = (g_rd & ~g_wr) ? ERR_DATA : '0;
        end
        state_nx = ST_IDLE;
        grant_nx = 2'b00;
        rr_nx    = ~owner;
        timer_nx = 16'd0;
        tcnt_nx  = sat_inc16(timeout_count);
      end

      default: begin
        state_nx = ST_IDLE;
        grant_nx = 2'b00;
        timer_nx = 16'd0;
      end
    endcase
  end

endmodule

// File: doc/avmm_m0_arb.md
Name: avmm_m0_arb

Overview:
- Two-requester arbiter that shares the single 8-bit Avalon-MM peripheral master port (address/read/write/writedata/readdata/waitrequest) between two independent requesters, e.g. CPU-side master and host-side SPI/PCIe bridge.
- Round-robin grant, locked for one complete transfer, plus a watchdog that terminates transfers the downstream slave never acknowledges.
- Sits between the requesters and the 8-bit peripheral register bank on the same clock domain.

Parameters:
- ADDR_W, 8, address width of all ports.
- DATA_W, 8, data width of all ports.
- TIMEOUT_CYC, 256, cycles in BUSY with m_waitrequest=1 before forced termination; legal range 2..65535.
- ERR_DATA, 8'hFF, readdata returned on a timed-out read.

Ports:
- clk_clk  in  1  clock.
- reset_reset  in  1  asynchronous, active-high reset.
- s0_address  in  ADDR_W  requester 0 address.
- s0_read  in  1  requester 0 read strobe.
- s0_write  in  1  requester 0 write strobe.
- s0_writedata  in  DATA_W  requester 0 write data.
- s0_readdata  out  DATA_W  requester 0 read data, valid when s0_waitrequest=0 on a read.
- s0_waitrequest  out  1  requester 0 stall.
- s1_address, s1_read, s1_write, s1_writedata, s1_readdata, s1_waitrequest: same as s0, for requester 1.
- m_address  out  ADDR_W  to peripheral.
- m_read  out  1  to peripheral.
- m_write  out  1  to peripheral.
- m_writedata  out  DATA_W  to peripheral.
- m_readdata  in  DATA_W  from peripheral.
- m_waitrequest  in  1  from peripheral.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- timeout_pulse  out  1  single-cycle pulse on a forced termination.
- timeout_count  out  16  saturating count of timeouts.

Behaviour:
- Reset (async, active-high): state=IDLE, grant=00, rr_ptr=0 (s0 has priority first), timer=0, timeout_count=0, timeout_pulse=0. m_read=m_write=0, m_address=0, m_writedata=0. s0_waitrequest=s1_waitrequest=1, s*_readdata=0.
- Request: sN_read|sN_write. If both strobes are asserted, the transfer is a write; the read is ignored.
- IDLE:
  - No request: stay in IDLE, all m outputs 0.
  - One requester active: register a grant to it.
  - Both active: grant the one selected by rr_ptr.
  - Next state is BUSY. Both s*_waitrequest stay 1 in IDLE.
- BUSY:
  - m_* are driven combinationally from the granted requester's inputs (strobe, address, writedata).
  - Granted sN_waitrequest = m_waitrequest; granted sN_readdata = m_readdata.
  - Non-granted requester: waitrequest=1, readdata=0.
- Completion: in BUSY, when m_waitrequest=0 with the strobe asserted:
  - The requester sees waitrequest=0 in that same cycle.
  - Next state is IDLE, rr_ptr points to the other requester, timer clears.
- Latency:
  - Grant takes 1 cycle (IDLE to BUSY). The m strobe is visible 1 cycle after the request.
  - Minimum requester-visible transfer is 2 cycles.
  - Back-to-back transfers from alternating requesters run at 1 IDLE cycle between them. No zero-bubble re-grant.
- Fairness: with both requesters continuously active, grants strictly alternate s0,s1,s0,...
- Timeout:
  - timer increments in every BUSY cycle with m_waitrequest=1.
  - When timer reaches TIMEOUT_CYC-1 and m_waitrequest is still 1, enter state TERM for 1 cycle.
  - In TERM: m_read=m_write=0; the granted sN_waitrequest=0; sN_readdata=ERR_DATA (reads only); timeout_pulse=1; timeout_count increments, saturating at 16'hFFFF.
  - TERM then goes to IDLE, rr_ptr toggles, timer clears.
  - If m_waitrequest falls in the same cycle the timer hits its limit, normal completion wins and no timeout is counted.
- Aborted request: if the granted requester drops both strobes while in BUSY (illegal Avalon), return to IDLE next cycle. No completion, no timeout, rr_ptr still toggles.
- Reset mid-transfer: all outputs take their reset values immediately (async). The downstream transfer is abandoned.
- grant is a registered copy of the owner: 00 in IDLE, 01 or 10 in BUSY/TERM.

Test Plan:
- Single write: s0_write=1, addr 8'h12, data 8'hA5; peripheral holds m_waitrequest=1 for 3 cycles. Required: m_write appears on cycle 1 with addr 12/data A5; s0_waitrequest falls on cycle 4; grant returns to 00 on cycle 5.
- Read: s1_read, addr 8'h30; peripheral returns 8'h5C with waitrequest=0 immediately. Required: s1_readdata=5C with s1_waitrequest=0 on cycle 1; s0 is untouched (waitrequest=1, readdata=0).
- Contention: both requesters assert continuously for 4 transfers (peripheral zero-wait). Required: grant sequence 01,10,01,10 after reset; each requester completes exactly 2 transfers.
- Timeout: TIMEOUT_CYC=8; s0_read with m_waitrequest stuck at 1. Required: TERM on cycle 8; s0_readdata=FF; s0_waitrequest=0 for 1 cycle; timeout_pulse for 1 cycle; timeout_count=1; next grant goes to s1 if it is pending.
- Boundary: m_waitrequest falls exactly on timer=TIMEOUT_CYC-1. Required: normal completion with real readdata; timeout_count unchanged; no timeout_pulse.
- Reset mid-transfer: assert reset_reset during BUSY. Required: m_read/m_write=0, grant=00 and s*_waitrequest=1 in the same cycle; after release, the first grant goes to s0.
